// File: rtl/ccu_seq_mult_shift_pkg.sv
// Shared control-section definitions for the CCU multiply/shift sequencer.
package ccu_seq_mult_shift_pkg;

    localparam int unsigned MC_PULSES_DEF   = 36;
    localparam int unsigned CNT_W_DEF       = 6;
    localparam int unsigned MULT_CYCLES_DEF = 35;

    typedef enum logic [1:0] {
        MODE_MULT = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_ILL  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic busy;
        logic g8;
        logic ds;
        logic da_m;
        logic shl;
        logic shr;
        logic done;
        logic err;
    } strobe_t;

endpackage

// File: rtl/ccu_pulse_counter.sv
// Free-running pulse-interval counter 0..MC_PULSES-1 with d0/d_last decodes.
module ccu_pulse_counter #(
    parameter  int unsigned MC_PULSES = 36,
    localparam int unsigned PC_W      = $clog2(MC_PULSES)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] count,
    output logic            d0,
    output logic            d_last
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(MC_PULSES - 1);

    logic [PC_W-1:0] count_q;
    logic [PC_W-1:0] count_d;

    always_comb begin
        count_d = (count_q == PC_LAST) ? '0 : count_q + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign d0     = (count_q == '0);
    assign d_last = (count_q == PC_LAST);

endmodule

// File: rtl/ccu_seq_mult_shift.sv
// Minor-cycle sequencer for serial multiply and left/right shifts; drives
// the digit-shift, add-multiplicand and gate-8 strobes of the arithmetic unit.
module ccu_seq_mult_shift
    import ccu_seq_mult_shift_pkg::*;
#(
    parameter int unsigned MC_PULSES   = MC_PULSES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             mplier_bit,
    output logic             busy,
    output logic             g8,
    output logic             ds,
    output logic             da_m,
    output logic             shl,
    output logic             shr,
    output logic             done,
    output logic             err,
    output logic             d0,
    output logic             d_last
);

    localparam int unsigned PC_W = $clog2(MC_PULSES);
    localparam strobe_t OUT_RST = '{g8: 1'b1, default: 1'b0};

    logic [PC_W-1:0] unused_pc;
    logic            pc_d0;
    logic            pc_dlast;

    state_e          state_q, state_d;
    mode_e           mode_q,  mode_d;
    logic [CNT_W-1:0] rem_q,  rem_d;
    strobe_t         out_q,   out_d;

    ccu_pulse_counter #(
        .MC_PULSES (MC_PULSES)
    ) u_pulse_counter (
        .clk    (clk),
        .rst    (rst),
        .count  (unused_pc),
        .d0     (pc_d0),
        .d_last (pc_dlast)
    );

    // Next state, latched operands and next registered strobes.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        out_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start && (mode != MODE_ILL)) begin
                    mode_d  = mode_e'(mode);
                    rem_d   = (mode == MODE_MULT) ? CNT_W'(MULT_CYCLES) : count;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (pc_dlast) begin
                    state_d = (rem_q == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // rem_q is never 0 here, so the decrement cannot wrap.
                if (pc_dlast) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_d.busy = (state_d != ST_IDLE);
        out_d.g8   = !((state_d == ST_ARM) || (state_d == ST_RUN));
        out_d.ds   = (state_d == ST_RUN) && pc_dlast;
        out_d.shl  = (state_d == ST_RUN) && (mode_q == MODE_SHL);
        out_d.shr  = (state_d == ST_RUN) && (mode_q == MODE_SHR);
        out_d.done = (state_d == ST_DONE);
        out_d.err  = (state_q == ST_IDLE) && start && (mode == MODE_ILL);

        // Multiplier digit captured at d0, held until the next d0 or exit.
        if (state_d == ST_RUN) begin
            if ((state_q == ST_RUN) && pc_d0) begin
                out_d.da_m = (mode_q == MODE_MULT) && mplier_bit;
            end else begin
                out_d.da_m = out_q.da_m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_MULT;
            rem_q   <= '0;
            out_q   <= OUT_RST;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    assign busy   = out_q.busy;
    assign g8     = out_q.g8;
    assign ds     = out_q.ds;
    assign da_m   = out_q.da_m;
    assign shl    = out_q.shl;
    assign shr    = out_q.shr;
    assign done   = out_q.done;
    assign err    = out_q.err;
    assign d0     = pc_d0;
    assign d_last = pc_dlast;

endmodule

// File: tb/tb_ccu_seq_mult_shift.sv
// Scoreboard bench for ccu_seq_mult_shift built with an 8-pulse minor cycle.
module tb_ccu_seq_mult_shift;
    import ccu_seq_mult_shift_pkg::*;

    localparam int MC   = 8;
    localparam int CW   = 6;
    localparam int MULT = 35;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] count = '0;
    logic          mplier_bit = 1'b0;
    logic          busy, g8, ds, da_m, shl, shr, done, err, d0, d_last;

    always #5 clk = ~clk;

    ccu_seq_mult_shift #(
        .MC_PULSES   (MC),
        .CNT_W       (CW),
        .MULT_CYCLES (MULT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .count      (count),
        .mplier_bit (mplier_bit),
        .busy       (busy),
        .g8         (g8),
        .ds         (ds),
        .da_m       (da_m),
        .shl        (shl),
        .shr        (shr),
        .done       (done),
        .err        (err),
        .d0         (d0),
        .d_last     (d_last)
    );

    typedef struct {
        bit          is_err;
        int          cyc;
        int          ds_n;
        int          busy_n;
        int          g8_n;
        int          shl_n;
        int          shr_n;
        int          da_n;
        logic [63:0] da_sig;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tb_pc  = 0;

    int          a_ds, a_busy, a_g8, a_shl, a_shr, a_da;
    logic [63:0] a_sig;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_acc();
        a_ds = 0; a_busy = 0; a_g8 = 0; a_shl = 0; a_shr = 0; a_da = 0; a_sig = '0;
    endtask

    // Reference phase: period index and pulse position as seen by the DUT.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tb_pc <= rst ? 0 : (tb_pc + 1) % MC;
    end

    // Monitor: accumulates per-operation activity, pops on done/err.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            clear_acc();
        end else begin
            chk("d0", 64'(d0), 64'(tb_pc == 0));
            chk("d_last", 64'(d_last), 64'(tb_pc == MC - 1));
            if (busy) a_busy++;
            if (!g8)  a_g8++;
            if (shl)  a_shl++;
            if (shr)  a_shr++;
            if (da_m) a_da++;
            if (ds) begin
                chk("ds_at_d0", 64'(tb_pc), 64'd0);
                a_ds++;
            end
            if (tb_pc == MC - 1 && a_ds > 0 && a_ds <= 64) a_sig[a_ds-1] = da_m;
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 64'(done) + 64'(err), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_err", 64'(err), 64'(e.is_err));
                    chk("event_kind_done", 64'(done), 64'(!e.is_err));
                    chk("event_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ds_pulses", 64'(a_ds), 64'(e.ds_n));
                    chk("busy_cycles", 64'(a_busy), 64'(e.busy_n));
                    chk("g8_low_cycles", 64'(a_g8), 64'(e.g8_n));
                    chk("shl_cycles", 64'(a_shl), 64'(e.shl_n));
                    chk("shr_cycles", 64'(a_shr), 64'(e.shr_n));
                    chk("da_m_cycles", 64'(a_da), 64'(e.da_n));
                    chk("da_m_digits", a_sig, e.da_sig);
                end
                clear_acc();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_g8", 64'(g8), 64'd1);
        chk("rst_ds", 64'(ds), 64'd0);
        chk("rst_da_m", 64'(da_m), 64'd0);
        chk("rst_shl", 64'(shl), 64'd0);
        chk("rst_shr", 64'(shr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_d0", 64'(d0), 64'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) begin
            tick();
            check_reset_outputs();
        end
        rst = 1'b0;
    endtask

    task automatic issue_err();
        exp_t e;
        e = '{is_err: 1'b1, cyc: cyc + 1, ds_n: 0, busy_n: 0, g8_n: 0,
              shl_n: 0, shr_n: 0, da_n: 0, da_sig: 64'd0};
        sb.push_back(e);
        start = 1'b1;
        mode  = 2'b11;
        count = CW'($urandom);
        tick();
        start = 1'b0;
        chk("err_busy", 64'(busy), 64'd0);
        tick();
    endtask

    // Issue one operation; the expectation comes from the minor-cycle arithmetic.
    task automatic run_op(input logic [1:0] m, input logic [CW-1:0] cnt,
                          input logic [63:0] bits, input bit at_dlast, input bit junk);
        exp_t e;
        int   p, acc_cyc, j, n, dn, t;
        if (at_dlast) while (tb_pc != MC - 1) tick();
        p       = tb_pc;
        acc_cyc = cyc + 1;
        n       = (m == MODE_MULT) ? MULT : int'(cnt);
        j       = (p == MC - 1) ? MC : MC - 1 - p;
        dn      = 0;
        for (int k = 0; k < n; k++) begin
            if (bits[k]) dn += MC - 1 + ((k < n - 1) ? 1 : 0);
        end
        e.is_err = 1'b0;
        e.cyc    = acc_cyc + j + n * MC;
        e.ds_n   = n;
        e.busy_n = j + n * MC + 1;
        e.g8_n   = j + n * MC;
        e.shl_n  = (m == MODE_SHL) ? n * MC : 0;
        e.shr_n  = (m == MODE_SHR) ? n * MC : 0;
        e.da_n   = (m == MODE_MULT) ? dn : 0;
        e.da_sig = (m == MODE_MULT) ? (bits & ((64'd1 << n) - 64'd1)) : 64'd0;
        sb.push_back(e);

        start = 1'b1;
        mode  = m;
        count = cnt;
        tick();
        while (cyc <= e.cyc) begin
            t = cyc - (acc_cyc + j);
            if (t >= 0 && (t % MC) == 0) mplier_bit = bits[t / MC];
            else                         mplier_bit = 1'($urandom);
            if (junk) begin
                start = 1'($urandom);
                mode  = 2'($urandom);
                count = CW'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    // Start a shift, then reset it partway through RUN with no scoreboard entry.
    task automatic reset_mid_run();
        int p, acc_cyc, j;
        p       = tb_pc;
        acc_cyc = cyc + 1;
        j       = (p == MC - 1) ? MC : MC - 1 - p;
        start = 1'b1;
        mode  = MODE_SHL;
        count = CW'(10);
        tick();
        start = 1'b0;
        while (cyc < acc_cyc + j + 2 * MC + 3) tick();
        chk("pre_rst_shl", 64'(shl), 64'd1);
        apply_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [1:0]    m;
        logic [CW-1:0] cnt;
        int            r;
        clear_acc();
        apply_reset();
        repeat (3) tick();

        issue_err();
        run_op(MODE_MULT, CW'(0), 64'h5555_5555_5555_5555, 1'b0, 1'b0);
        run_op(MODE_SHL, CW'(5), 64'd0, 1'b0, 1'b0);
        run_op(MODE_SHR, CW'(0), 64'd0, 1'b0, 1'b0);
        run_op(MODE_SHL, CW'(63), {$urandom(), $urandom()}, 1'b1, 1'b0);
        run_op(MODE_SHR, CW'(7), {$urandom(), $urandom()}, 1'b1, 1'b1);
        run_op(MODE_MULT, CW'($urandom), {$urandom(), $urandom()}, 1'b0, 1'b1);

        repeat (5) tick();
        reset_mid_run();
        run_op(MODE_SHR, CW'(3), 64'd0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            m = 2'($urandom);
            if (m == 2'b11) begin
                issue_err();
            end else begin
                r   = int'($urandom_range(0, 9));
                cnt = (r == 0) ? CW'(0) : (r == 1) ? CW'(63) : CW'($urandom_range(1, 20));
                run_op(m, cnt, {$urandom(), $urandom()}, 1'($urandom), 1'($urandom));
            end
            repeat ($urandom_range(0, 2 * MC)) tick();
        end

        repeat (4) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
